// File: rtl/zpu_wb_pkg.sv
// Shared types and helpers for the ZPU Wishbone RAM slave.
// Holds the access FSM encoding, bus widths and the address-window decode.
package zpu_wb_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFinish
  } wb_state_e;

  // The window covers 2**(aw+2) bytes, so only the bits above that span are compared.
  function automatic logic wb_addr_hit(input logic [31:0] adr, input logic [31:0] base,
                                       input int unsigned aw);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (aw + 2);
    return (adr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/zpu_wb_ram_array.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
// The read register only updates on read operations, so it holds the last word read.
module zpu_wb_ram_array
  import zpu_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WB_SELW-1:0]    be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DW-1:0]      wdata,
  output logic [WB_DW-1:0]      rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WB_DW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WB_SELW; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/zpu_wb_slave_ram.sv
// Pipelined Wishbone B4 slave fronting an on-chip RAM window, with programmable
// wait states, byte-lane writes, stall back-pressure and err for out-of-window addresses.
module zpu_wb_slave_ram
  import zpu_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall
);

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  wb_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        ack_q, ack_d, err_q, err_d;
  logic        dat_zero_q, dat_zero_d;

  logic        accept;
  logic        op_fire, op_we, op_hit;
  logic [31:0] op_adr, op_dat;
  logic [3:0]  op_sel;
  logic [31:0] ram_rdata;

  assign wb_stall = (state_q != StIdle);
  assign accept   = wb_cyc & wb_stb & ~wb_stall;

  // Zero wait states operate straight off the bus in the accept cycle;
  // otherwise the latched request is executed at the end of the last stall cycle.
  always_comb begin
    if (WAIT_STATES == 0) begin
      op_fire = accept;
      op_we   = wb_we;
      op_adr  = wb_adr;
      op_sel  = wb_sel;
      op_dat  = wb_dat_i;
    end else begin
      op_fire = (state_q == StFinish) & wb_cyc;
      op_we   = we_q;
      op_adr  = adr_q;
      op_sel  = sel_q;
      op_dat  = dat_q;
    end
  end

  assign op_hit = wb_addr_hit(op_adr, BASE_ADDR, ADDR_WIDTH);

  zpu_wb_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (op_fire & op_hit),
    .we    (op_we),
    .be    (op_sel),
    .addr  (op_adr[ADDR_WIDTH+1:2]),
    .wdata (op_dat),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept && (WAIT_STATES != 0)) begin
          cnt_d   = WaitCnt;
          state_d = (WAIT_STATES == 1) ? StFinish : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd2) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    // Master gave up the cycle: drop the pending access silently.
    if ((state_q != StIdle) && !wb_cyc) begin
      cnt_d   = '0;
      state_d = StIdle;
    end
  end

  always_comb begin
    ack_d      = op_fire & op_hit;
    err_d      = op_fire & ~op_hit;
    dat_zero_d = dat_zero_q;
    if (op_fire && !op_we) begin
      dat_zero_d = ~op_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_zero_q <= dat_zero_d;
      if (accept) begin
        adr_q <= wb_adr;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel;
        we_q  <= wb_we;
      end
    end
  end

  assign wb_ack   = ack_q & wb_cyc;
  assign wb_err   = err_q & wb_cyc;
  assign wb_dat_o = (err_q | dat_zero_q) ? '0 : ram_rdata;

endmodule

// File: tb/tb_zpu_wb_slave_ram.sv
// Bench for zpu_wb_slave_ram: three instances (0, 2 and 3 wait states, one with a
// non-zero base) driven by a vector table, random accesses and hand-written corner cases.
module tb_zpu_wb_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic        ack   [3];
  logic        err   [3];
  logic        stall [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zpu_wb_slave_ram #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_adr(adr[0]),
    .wb_sel(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack(ack[0]), .wb_err(err[0]),
    .wb_stall(stall[0]));

  zpu_wb_slave_ram #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_adr(adr[1]),
    .wb_sel(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack(ack[1]), .wb_err(err[1]),
    .wb_stall(stall[1]));

  zpu_wb_slave_ram #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]), .wb_adr(adr[2]),
    .wb_sel(sel[2]), .wb_dat_i(wdat[2]), .wb_dat_o(rdat[2]), .wb_ack(ack[2]), .wb_err(err[2]),
    .wb_stall(stall[2]));

  function automatic int unsigned ws(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h0001_0000 : 32'h0000_0000;
  endfunction

  // Window is 4 KiWords = 16 KiB starting at the base.
  function automatic logic model_hit(input int d, input logic [31:0] a);
    return (a >= base_of(d)) && ((a - base_of(d)) < 32'h0000_4000);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] && err[i]) begin
        bad++;
        $display("FAIL ack_err_overlap dut%0d: got ack=1 err=1 expected at most one", i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called and returns at posedge+1; leaves cyc high, stb low, in the termination cycle.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] v, output logic got_ack, output logic got_err,
                        output logic [31:0] rd, output int lat);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = v;
    @(posedge clk); #1;
    stb[d] = 1'b0;
    lat = 1;
    while (!(ack[d] || err[d]) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got_ack = ack[d];
    got_err = err[d];
    rd      = rdat[d];
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] v;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] mdl [3][16];
  logic        ga, ge;
  logic [31:0] gd;
  int          gl;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; sel[i] = '0; wdat[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("rst_ack%0d", i), ack[i], 1'b0);
      check1($sformatf("rst_err%0d", i), err[i], 1'b0);
      check1($sformatf("rst_stall%0d", i), stall[i], 1'b0);
      check32($sformatf("rst_dat%0d", i), rdat[i], 32'h0);
    end
    rst = 1'b0;

    // Directed vectors on the zero-wait-state instance.
    tbl[0]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
    tbl[3]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 4'h3, 32'h0,         1'b0, 32'h1234_5678};
    tbl[6]  = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0002, 4'hF, 32'h0,         1'b0, 32'h1234_5678};
    tbl[9]  = '{1'b1, 32'h0000_3FFC, 4'hF, 32'h0,         1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_3FFC, 4'hA, 32'h9988_7766, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_3FFF, 4'hF, 32'h0,         1'b0, 32'h9900_7700};
    tbl[12] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b1, 32'h0};
    for (int i = 0; i < 13; i++) begin
      access(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].v, ga, ge, gd, gl);
      check1($sformatf("tbl%0d_ack", i), ga, ~tbl[i].exp_err);
      check1($sformatf("tbl%0d_err", i), ge, tbl[i].exp_err);
      check32($sformatf("tbl%0d_lat", i), 32'(gl), 32'd1);
      if (!tbl[i].w) check32($sformatf("tbl%0d_dat", i), gd, tbl[i].exp_dat);
    end

    // Random accesses against a word-array model, every instance.
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        mdl[d][w] = $urandom;
        access(d, 1'b1, base_of(d) + 32'(w * 4), 4'hF, mdl[d][w], ga, ge, gd, gl);
        check1($sformatf("fill%0d_%0d_ack", d, w), ga, 1'b1);
      end
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a, v;
        logic [3:0]  s;
        logic        w, h;
        int unsigned idx;
        idx = $urandom_range(0, 15);
        if ($urandom_range(0, 7) != 0)
          a = base_of(d) + (idx << 2) + $urandom_range(0, 3);
        else if ($urandom_range(0, 1) == 1)
          a = base_of(d) + 32'h4000 + ($urandom_range(0, 1023) << 2);
        else
          a = base_of(d) - 32'd4 - ($urandom_range(0, 255) << 2);
        w = 1'($urandom_range(0, 1));
        s = 4'($urandom_range(0, 15));
        v = $urandom;
        h = model_hit(d, a);
        access(d, w, a, s, v, ga, ge, gd, gl);
        check1($sformatf("rnd%0d_%0d_ack", d, n), ga, h);
        check1($sformatf("rnd%0d_%0d_err", d, n), ge, ~h);
        check32($sformatf("rnd%0d_%0d_lat", d, n), 32'(gl), 32'(ws(d) + 1));
        if (!w) check32($sformatf("rnd%0d_%0d_dat", d, n), gd, h ? mdl[d][idx] : 32'h0);
        if (w && h) begin
          for (int b = 0; b < 4; b++) if (s[b]) mdl[d][idx][8*b +: 8] = v[8*b +: 8];
        end
      end
    end

    // Back-to-back write then read, zero wait states.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; sel[0] = 4'hF;
    wdat[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check1("b2b_wr_ack", ack[0], 1'b1);
    check1("b2b_wr_stall", stall[0], 1'b0);
    we[0] = 1'b0;
    @(posedge clk); #1;
    check1("b2b_rd_ack", ack[0], 1'b1);
    check1("b2b_rd_stall", stall[0], 1'b0);
    check32("b2b_rd_dat", rdat[0], 32'hDEAD_BEEF);
    stb[0] = 1'b0;
    @(posedge clk); #1;
    check1("b2b_idle_ack", ack[0], 1'b0);

    // Four reads held on stb with three wait states: accepts every fourth cycle.
    for (int w = 0; w < 4; w++) begin
      access(2, 1'b1, base_of(2) + 32'h40 + 32'(w * 4), 4'hF, 32'hC0DE_0000 + 32'(w),
             ga, ge, gd, gl);
      check1($sformatf("pipe_fill%0d", w), ga, 1'b1);
    end
    begin
      int nacks;
      nacks = 0;
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = base_of(2) + 32'h40;
      for (int k = 1; k <= 16; k++) begin
        @(posedge clk); #1;
        check1($sformatf("pipe_stall_c%0d", k), stall[2], (k % 4) != 0);
        check1($sformatf("pipe_ack_c%0d", k), ack[2], (k % 4) == 0);
        if (ack[2]) begin
          check32($sformatf("pipe_dat%0d", nacks), rdat[2], 32'hC0DE_0000 + 32'(nacks));
          nacks++;
        end
        if (k == 1 || k == 5 || k == 9) adr[2] = adr[2] + 32'd4;
        if (k == 13) stb[2] = 1'b0;
      end
      check32("pipe_nacks", 32'(nacks), 32'd4);
    end

    // Abort: cyc dropped in the first stall cycle of a write.
    access(1, 1'b1, 32'h30, 4'hF, 32'h0000_00AA, ga, ge, gd, gl);
    check1("abort_pre_ack", ga, 1'b1);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; sel[1] = 4'hF;
    wdat[1] = 32'h0000_0055;
    @(posedge clk); #1;
    check1("abort_stall_t1", stall[1], 1'b1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    check1("abort_stall_t2", stall[1], 1'b0);
    check1("abort_ack_t2", ack[1], 1'b0);
    check1("abort_err_t2", err[1], 1'b0);
    cyc[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1($sformatf("abort_noterm_ack%0d", k), ack[1], 1'b0);
      check1($sformatf("abort_noterm_err%0d", k), err[1], 1'b0);
    end
    access(1, 1'b0, 32'h30, 4'hF, 32'h0, ga, ge, gd, gl);
    check1("abort_rb_ack", ga, 1'b1);
    check32("abort_rb_dat", gd, 32'h0000_00AA);

    // Reset during a pending write.
    access(1, 1'b1, 32'h34, 4'hF, 32'h0BAD_F00D, ga, ge, gd, gl);
    check1("rstmid_pre_ack", ga, 1'b1);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h34; sel[1] = 4'hF;
    wdat[1] = 32'h1111_1111;
    @(posedge clk); #1;
    rst = 1'b1;
    stb[1] = 1'b0;
    @(posedge clk); #1;
    check1("rstmid_ack", ack[1], 1'b0);
    check1("rstmid_err", err[1], 1'b0);
    check1("rstmid_stall", stall[1], 1'b0);
    check32("rstmid_dat", rdat[1], 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1($sformatf("rstmid_noterm_ack%0d", k), ack[1], 1'b0);
      check1($sformatf("rstmid_noterm_err%0d", k), err[1], 1'b0);
    end
    access(1, 1'b0, 32'h34, 4'hF, 32'h0, ga, ge, gd, gl);
    check1("rstmid_rb_ack", ga, 1'b1);
    check32("rstmid_rb_dat", gd, 32'h0BAD_F00D);

    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
